// File: rtl/button_event_ctrl.sv
// Debounces N push buttons on a slow tick, classifies press / long-press / release
// per button and serialises all events onto one valid/ready stream (round-robin).
module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int IDW        = 2,
  parameter int TICK_DIV   = 100000,
  parameter int DB_LEN     = 4,
  parameter int LONG_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb_in,
  output logic [N_BTN-1:0] pb_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_btn,
  output logic [1:0]       evt_type,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_LONG  = 2'b10;
  localparam logic [1:0] T_REL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PRESSED = 2'b01,
    S_HELD    = 2'b10
  } state_t;

  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         tick_s;
  logic [N_BTN-1:0][DB_LEN-1:0] win_q, win_d;
  logic [N_BTN-1:0]             lvl_q, lvl_d;
  state_t                       st_q [N_BTN];
  state_t                       st_d [N_BTN];
  logic [N_BTN-1:0][HW-1:0]     hold_q, hold_d;
  // Pending flags per button: [0] press, [1] long, [2] release
  logic [N_BTN-1:0][2:0]        pend_q, pend_d, set_s, clr_s;
  logic                         ovf_q, ovf_d, ovf_set_s;
  logic                         vld_q, vld_d;
  logic [IDW-1:0]               btn_q, btn_d, rr_q, rr_d, idx_s;
  logic [1:0]                   typ_q, typ_d;
  logic                         found_s;

  assign tick_s    = (cnt_q == CW'(TICK_DIV - 1));
  assign pb_level  = lvl_q;
  assign evt_valid = vld_q;
  assign evt_btn   = btn_q;
  assign evt_type  = typ_q;
  assign overflow  = ovf_q;

  always_comb begin
    cnt_d = tick_s ? '0 : cnt_q + CW'(1);
    win_d = win_q;
    lvl_d = lvl_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (tick_s) begin
        win_d[i] = {win_q[i][DB_LEN-2:0], pb_in[i]};
        // Level moves only on a fully settled window; mixed windows hold it
        if (&{win_q[i][DB_LEN-2:0], pb_in[i]}) begin
          lvl_d[i] = 1'b1;
        end else if (~|{win_q[i][DB_LEN-2:0], pb_in[i]}) begin
          lvl_d[i] = 1'b0;
        end else begin
          lvl_d[i] = lvl_q[i];
        end
      end else begin
        win_d[i] = win_q[i];
        lvl_d[i] = lvl_q[i];
      end
    end
  end

  always_comb begin
    hold_d = hold_q;
    set_s  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        S_IDLE: begin
          if (lvl_q[i]) begin
            st_d[i]     = S_PRESSED;
            set_s[i][0] = 1'b1;
            hold_d[i]   = '0;
          end else begin
            st_d[i] = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (!lvl_q[i]) begin
            st_d[i]     = S_IDLE;
            set_s[i][2] = 1'b1;
          end else if (tick_s && (hold_q[i] < HW'(LONG_TICKS))) begin
            hold_d[i] = hold_q[i] + HW'(1);
            if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
              st_d[i]     = S_HELD;
              set_s[i][1] = 1'b1;
            end else begin
              st_d[i] = S_PRESSED;
            end
          end else begin
            st_d[i] = S_PRESSED;
          end
        end
        S_HELD: begin
          if (!lvl_q[i]) begin
            st_d[i]     = S_IDLE;
            set_s[i][2] = 1'b1;
          end else begin
            st_d[i] = S_HELD;
          end
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d   = vld_q;
    btn_d   = btn_q;
    typ_d   = typ_q;
    rr_d    = rr_q;
    clr_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    if (!vld_q || evt_ready) begin
      vld_d = 1'b0;
      // Scan starts one past the last grant so every button gets a turn
      for (int k = 1; k <= N_BTN; k++) begin
        idx_s = IDW'((int'(rr_q) + k) % N_BTN);
        if (!found_s && (pend_q[idx_s] != 3'b000)) begin
          found_s = 1'b1;
          vld_d   = 1'b1;
          btn_d   = idx_s;
          rr_d    = idx_s;
          if (pend_q[idx_s][0]) begin
            typ_d            = T_PRESS;
            clr_s[idx_s][0] = 1'b1;
          end else if (pend_q[idx_s][1]) begin
            typ_d            = T_LONG;
            clr_s[idx_s][1] = 1'b1;
          end else begin
            typ_d            = T_REL;
            clr_s[idx_s][2] = 1'b1;
          end
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // A new set beats a same-cycle arbiter clear and a same-cycle overflow_clr
  always_comb begin
    pend_d    = pend_q;
    ovf_set_s = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      pend_d[i] = (pend_q[i] & ~clr_s[i]) | set_s[i];
      if ((set_s[i] & pend_q[i] & ~clr_s[i]) != 3'b000) begin
        ovf_set_s = 1'b1;
      end else begin
        ovf_set_s = ovf_set_s;
      end
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      win_q  <= '0;
      lvl_q  <= '0;
      hold_q <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
      btn_q  <= '0;
      typ_q  <= 2'b00;
      rr_q   <= IDW'(N_BTN - 1);
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i] <= S_IDLE;
      end
    end else begin
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      lvl_q  <= lvl_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
      btn_q  <= btn_d;
      typ_q  <= typ_d;
      rr_q   <= rr_d;
      for (int i = 0; i < N_BTN; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: a tick-level reference model predicts
// per-button event order; a monitor pops and compares every accepted event.
module tb_button_event_ctrl;

  localparam int N_BTN = 4;
  localparam int DB    = 4;
  localparam int LONG  = 3;
  localparam int TDIV  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb_in;
  logic [3:0] pb_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic       overflow;
  logic       overflow_clr;

  button_event_ctrl #(
    .N_BTN(N_BTN), .IDW(2), .TICK_DIV(TDIV), .DB_LEN(DB), .LONG_TICKS(LONG)
  ) dut (
    .clk(clk), .rst(rst), .pb_in(pb_in), .pb_level(pb_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_type(evt_type), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int btn; int typ; } ev_t;
  typedef struct { int btn; int typ; int cyc; } lg_t;

  ev_t exp_q[$];
  lg_t log_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  rdy_mode   = 2;   // 0: random (ready at least every other cycle), 1: always, 2: never
  int  stall_len  = 0;

  // Reference model state, one entry per button, advanced once per sample tick
  int run1[N_BTN];
  int run0[N_BTN];
  int mlvl[N_BTN];
  int hcnt[N_BTN];
  int ldone[N_BTN];

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      run1[i] = 0; run0[i] = DB; mlvl[i] = 0; hcnt[i] = 0; ldone[i] = 0;
    end
  endtask

  task automatic model_tick(input logic [3:0] v);
    for (int i = 0; i < N_BTN; i++) begin
      // Ticks spent held after the press tick, counted on the level seen before this sample
      if (mlvl[i] == 1 && ldone[i] == 0) begin
        hcnt[i]++;
        if (hcnt[i] == LONG) begin
          exp_q.push_back('{btn: i, typ: 2});
          ldone[i] = 1;
        end
      end
      if (v[i]) begin run1[i]++; run0[i] = 0; end
      else      begin run0[i]++; run1[i] = 0; end
      if (run1[i] >= DB && mlvl[i] == 0) begin
        mlvl[i] = 1; hcnt[i] = 0; ldone[i] = 0;
        exp_q.push_back('{btn: i, typ: 1});
      end else if (run0[i] >= DB && mlvl[i] == 1) begin
        mlvl[i] = 0;
        exp_q.push_back('{btn: i, typ: 3});
      end
    end
  endtask

  // One full sample period: drive, predict, let the DUT tick, check debounced levels
  task automatic do_tick(input logic [3:0] v);
    int lv;
    pb_in = v;
    model_tick(v);
    repeat (TDIV) @(posedge clk);
    #1;
    lv = 0;
    for (int i = 0; i < N_BTN; i++) lv = lv | (mlvl[i] << i);
    chk("pb_level", int'(pb_level), lv);
  endtask

  task automatic pulse_twice(input logic [3:0] v);
    repeat (2) begin
      repeat (DB) do_tick(v);
      repeat (DB) do_tick(4'b0000);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       evt_ready = (cyc % 2 == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
        1:       evt_ready = 1'b1;
        default: evt_ready = 1'b0;
      endcase
    end
  end

  // Monitor: output-hold check while stalled, scoreboard pop on every handshake
  initial begin
    int fi;
    int prev_stall;
    int prev_word;
    prev_stall = 0;
    prev_word  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        stall_len  = 0;
      end else begin
        if (prev_stall == 1)
          chk("hold_stable", int'({evt_valid, evt_btn, evt_type}), prev_word);
        if (evt_valid && evt_ready) begin
          fi = -1;
          foreach (exp_q[j]) if (fi < 0 && exp_q[j].btn == int'(evt_btn)) fi = j;
          if (fi < 0) begin
            chk($sformatf("unexpected_evt_btn%0d_type", evt_btn), int'(evt_type), 0);
          end else begin
            chk($sformatf("evt_type_btn%0d", evt_btn), int'(evt_type), exp_q[fi].typ);
            exp_q.delete(fi);
          end
          log_q.push_back('{btn: int'(evt_btn), typ: int'(evt_type), cyc: cyc});
        end
        stall_len  = (evt_valid && !evt_ready) ? stall_len + 1 : 0;
        prev_stall = (evt_valid && !evt_ready) ? 1 : 0;
        prev_word  = int'({evt_valid, evt_btn, evt_type});
      end
    end
  end

  initial begin
    logic [3:0] v;
    rst = 1'b1; pb_in = 4'b0000; overflow_clr = 1'b0; rdy_mode = 2;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_pb_level", int'(pb_level), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_btn", int'(evt_btn), 0);
    chk("rst_evt_type", int'(evt_type), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Round-robin: rr starts at N_BTN-1, so button 0 wins, then 2; after granting 2, 0 again
    rdy_mode = 1;
    log_q.delete();
    repeat (9) do_tick(4'b0101);
    repeat (5) do_tick(4'b0000);
    chk("rr_log_size", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("rr_press_first", log_q[0].btn, 0);
      chk("rr_press_second", log_q[1].btn, 2);
      chk("rr_press_gap", log_q[1].cyc - log_q[0].cyc, 1);
      chk("rr_rel_first", log_q[4].btn, 0);
      chk("rr_rel_second", log_q[5].btn, 2);
      chk("rr_rel_gap", log_q[5].cyc - log_q[4].cyc, 1);
    end

    // Bounce on button 0: only one event until the level is settled
    rdy_mode = 0;
    log_q.delete();
    do_tick(4'b0001); do_tick(4'b0000); do_tick(4'b0001);
    repeat (4) do_tick(4'b0001);
    chk("bounce_log_size", log_q.size(), 1);
    if (log_q.size() == 1) chk("bounce_btn", log_q[0].btn, 0);
    repeat (5) do_tick(4'b0000);

    // Long press on button 1: press, one long, release
    log_q.delete();
    repeat (12) do_tick(4'b0010);
    repeat (5) do_tick(4'b0000);
    chk("long_log_size", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("long_seq0", log_q[0].typ, 1);
      chk("long_seq1", log_q[1].typ, 2);
      chk("long_seq2", log_q[2].typ, 3);
    end

    // Backpressure on button 3
    rdy_mode = 2;
    repeat (10) do_tick(4'b1000);
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_evt", int'({evt_btn, evt_type}), int'({2'd3, 2'b01}));
    chk("bp_stall_ge20", int'(stall_len >= 20), 1);
    rdy_mode = 0;
    repeat (5) do_tick(4'b0000);

    // Randomised activity on all buttons
    v = 4'b0000;
    repeat (60) begin
      for (int i = 0; i < N_BTN; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      do_tick(v);
    end
    repeat (6) do_tick(4'b0000);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_overflow", int'(overflow), 0);

    // Overflow: the first press sits in the stalled output slot, so the second press
    // finds its flag free; the second long and release collide and are dropped.
    rdy_mode = 2;
    pulse_twice(4'b0010);
    chk("ovf_set", int'(overflow), 1);
    for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].btn == 1) exp_q.delete(j);
    exp_q.push_back('{btn: 1, typ: 1});
    exp_q.push_back('{btn: 1, typ: 1});
    exp_q.push_back('{btn: 1, typ: 2});
    exp_q.push_back('{btn: 1, typ: 3});
    rdy_mode = 0;
    repeat (3) do_tick(4'b0000);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_sticky", int'(overflow), 1);
    overflow_clr = 1'b1;
    do_tick(4'b0000);
    overflow_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Asynchronous reset with an event held in the output register
    rdy_mode = 2;
    pulse_twice(4'b0010);
    repeat (DB) do_tick(4'b0010);
    chk("pre_rst_valid", int'(evt_valid), 1);
    chk("pre_rst_overflow", int'(overflow), 1);
    chk("pre_rst_level", int'(pb_level), 2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(evt_valid), 0);
    chk("async_rst_level", int'(pb_level), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    exp_q.delete();
    model_reset();
    pb_in = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;

    // Recovery after reset
    rdy_mode = 0;
    repeat (4) do_tick(4'b0100);
    repeat (5) do_tick(4'b0000);

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_overflow", int'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
